prim_chain_pipe: RTL and testbench
==================================

Name: prim_chain_pipe

Overview:
- Pipelined, handshaked successor to the combinational pair-primitive chain benchmark.
- Each stage applies the pair primitive to every 2-bit pair (hi, lo):
  - Increment mode: lo' = ~lo, hi' = hi ^ lo, i.e. pair + 1 mod 4.
  - Decrement mode: lo' = ~lo, hi' = hi ^ ~lo, i.e. pair - 1 mod 4.
- Every stage is registered, so correctness and throughput can be checked in the simulator with backpressure.
- Sits between the stimulus source and the result checker in the correctness harness.

Parameters:
- IO_PAIRS, 4, number of independent 2-bit pairs; data width is IO_PAIRS*2.
- DEPTH, 3, number of serial primitive stages, and also the number of pipeline registers; legal range DEPTH >= 1.
- OCC_W, $clog2(DEPTH+1), width of the occupancy output.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word offered.
- in_ready  out  1  pipeline can accept the input word this cycle.
- in_data  in  IO_PAIRS*2  input word; pair j occupies bits [2j+1:2j].
- in_dec  in  1  mode for this word: 0 = increment, 1 = decrement; travels with the word.
- out_valid  out  1  result word available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  IO_PAIRS*2  result word.
- out_dec  out  1  mode bit the result word was processed with.
- occupancy  out  OCC_W  number of valid words currently in the pipeline, range 0..DEPTH.

Behaviour:
- Stage state: each stage k (0..DEPTH-1) holds v[k], d[k] and m[k].
  - Stage 0 loads f(in_data, in_dec).
  - Stage k>0 loads f(d[k-1], m[k-1]).
  - f applies the primitive once to every pair.
- Outputs: out_valid = v[DEPTH-1], out_data = d[DEPTH-1], out_dec = m[DEPTH-1].
- Advance rule: stage k can take a word iff !v[k] or stage k empties this cycle.
  - The last stage empties on out_ready.
  - Stage k<DEPTH-1 empties when stage k+1 takes its word.
  - in_ready = stage 0 can take a word.
  - in_ready must not depend combinationally on in_valid.
- Transfers: an input transfer occurs on in_valid && in_ready; an output transfer on out_valid && out_ready.
- Bubbles: a stage that empties without being refilled clears v[k]. Data in invalid stages is don't-care but must not reach out_data while out_valid = 1.
- Latency: a word accepted at edge N is presented at out_valid after DEPTH edges when there is no stall (visible DEPTH cycles after acceptance).
- Throughput: 1 word/cycle when out_ready is held at 1.
- Stall: while out_valid && !out_ready, out_data and out_dec hold stable.
  - Upstream bubbles compress: the pipeline fills to DEPTH words, then in_ready = 0.
- Arithmetic reference: each output pair = (input pair + DEPTH) mod 4 for increment, or (input pair - DEPTH) mod 4 for decrement.
  - Pairs are independent; there is no carry between pairs.
  - Modes may mix word-to-word with no extra bubble.
- occupancy:
  - +1 on an input transfer, -1 on an output transfer, unchanged when both occur in the same cycle.
  - Always equals the popcount of v.
  - Never exceeds DEPTH and never underflows.
- Reset (rst = 1 at an edge):
  - v, occupancy, d and m all go to 0, so out_valid = 0, out_data = 0, out_dec = 0.
  - in_ready reads 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight words; no partial word is emitted afterwards.
  - Input presented during a reset cycle is ignored.
- Ordering: words exit in the order they were accepted; no reordering and no duplication.
- DEPTH = 1: degenerates to a single register slice with the same handshake rules.

Test Plan:
- Reset, then in_data=8'h00, in_dec=0, out_ready=1 -> out_valid rises 3 cycles after acceptance with out_data=8'hFF, out_dec=0; occupancy returns to 0.
- in_data=8'hE4, in_dec=0 -> out_data=8'h93. The same word with in_dec=1 -> out_data=8'h39, out_dec=1.
- Stream 8'h00..8'h0F on consecutive cycles with out_ready=1 -> 16 results on consecutive cycles, in order, each matching (pair ± 3) mod 4; in_ready stays 1 throughout.
- Hold out_ready=0 while streaming:
  - After 3 accepts, in_ready=0 and occupancy=3.
  - out_data is stable for the whole stall.
  - Raising out_ready drains the words in order with no loss or duplication.
- Random in_valid/out_ready (≥10k cycles, mixed in_dec) -> scoreboard matches the arithmetic reference; occupancy always equals accepted minus emitted and stays ≤ 3.
- Assert rst for 1 cycle with 2 words in flight -> out_valid=0, occupancy=0 the next cycle, and no stale word ever appears; the next accepted word's result arrives with normal latency. Repeat the key checks with DEPTH=1, IO_PAIRS=1.

Source files
------------

// File: rtl/prim_chain_pipe.sv
// rtl/prim_chain_pipe.sv - pipelined, handshaked chain of 2-bit pair primitives
//
// Purpose: DEPTH registered stages, each applying the pair primitive once to
// every 2-bit pair of the word (increment: pair+1 mod 4, decrement: pair-1
// mod 4). The mode bit travels with its word. Valid/ready on both sides,
// with full throughput and stall-tolerant backpressure.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake
//   in_data, in_dec        input word (pair j at [2j+1:2j]) and its mode
//   out_valid/out_ready    output handshake
//   out_data, out_dec      result word and the mode it was processed with
//   occupancy              number of valid words held, 0..DEPTH
module prim_chain_pipe #(
  parameter int IO_PAIRS = 4,
  parameter int DEPTH    = 3,
  parameter int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IO_PAIRS*2-1:0] in_data,
  input  logic                  in_dec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IO_PAIRS*2-1:0] out_data,
  output logic                  out_dec,
  output logic [OCC_W-1:0]      occupancy
);

  localparam int W = IO_PAIRS * 2;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] m;
  logic [W-1:0]     d [DEPTH];

  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] drain;
  logic [W-1:0]     nxt_d [DEPTH];
  logic [DEPTH-1:0] nxt_m;
  logic             take_next;
  logic             stage_take;
  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ;

  // One primitive step on every pair: lo' = ~lo, hi' = hi ^ lo (inc) or
  // hi ^ ~lo (dec). The dec case folds into hi ^ lo ^ dec.
  function automatic logic [W-1:0] prim(input logic [W-1:0] x, input logic dec);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < IO_PAIRS; j++) begin
      r[2*j]   = ~x[2*j];
      r[2*j+1] = x[2*j+1] ^ x[2*j] ^ dec;
    end
    return r;
  endfunction

  // Valid bit feeding each stage: in_valid for stage 0, v[k-1] otherwise.
  assign up_v  = (v << 1) | DEPTH'(in_valid);
  assign nxt_m = (m << 1) | DEPTH'(in_dec);

  always_comb begin
    nxt_d[0] = prim(in_data, in_dec);
    for (int k = 1; k < DEPTH; k++) begin
      nxt_d[k] = prim(d[k-1], m[k-1]);
    end
  end

  // Ready ripples from the output back to the input. Walking the stages from
  // last to first with a scalar carry keeps this a simple chain; it never
  // touches in_valid, so in_ready is independent of in_valid.
  always_comb begin
    load       = '0;
    drain      = '0;
    take_next  = 1'b0;
    stage_take = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (k == DEPTH - 1) begin
        drain[k] = v[k] & out_ready;
      end else begin
        drain[k] = v[k] & take_next;
      end
      stage_take = ~v[k] | drain[k];
      load[k]    = stage_take & up_v[k];
      take_next  = stage_take;
    end
  end

  assign in_ready  = take_next;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = v[DEPTH-1] & out_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign out_dec   = m[DEPTH-1];
  assign occupancy = occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      m   <= '0;
      occ <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          v[k] <= 1'b1;
          d[k] <= nxt_d[k];
          m[k] <= nxt_m[k];
        end else if (drain[k]) begin
          // Emptied without a refill: becomes a bubble, data left as-is.
          v[k] <= 1'b0;
        end
      end
      if (in_xfer && !out_xfer) begin
        occ <= occ + OCC_W'(1);
      end else if (!in_xfer && out_xfer) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prim_chain_pipe.sv
// tb/tb_prim_chain_pipe.sv - self-checking bench for prim_chain_pipe (DEPTH=3/IO_PAIRS=4 and DEPTH=1/IO_PAIRS=1)
module tb_prim_chain_pipe;

  localparam int P  = 4;
  localparam int D  = 3;
  localparam int P1 = 1;
  localparam int D1 = 1;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_dec;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_dec;
  logic [7:0] a_out_data;
  logic [1:0] a_occ;

  logic       b_in_ready, b_out_valid, b_out_dec;
  logic [1:0] b_out_data;
  logic       b_occ;
  logic [1:0] b_in_data;

  assign b_in_data = in_data[1:0];

  prim_chain_pipe #(.IO_PAIRS(P), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_dec(in_dec),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_dec(a_out_dec),
    .occupancy(a_occ)
  );

  prim_chain_pipe #(.IO_PAIRS(P1), .DEPTH(D1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_dec(in_dec),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_dec(b_out_dec),
    .occupancy(b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       dec;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       dec;
    logic [7:0] exp_a;
    logic [1:0] exp_b;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic stall_a, stall_b;
  exp_t held_a, held_b;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: each pair moves by +/-depth mod 4.
  function automatic logic [7:0] model(input logic [7:0] x, input logic dec,
                                       input int depth, input int pairs);
    logic [7:0] r;
    int p;
    r = '0;
    for (int j = 0; j < pairs; j++) begin
      p = int'(x[2*j +: 2]);
      p = dec ? ((p - depth) & 3) : ((p + depth) & 3);
      r[2*j +: 2] = 2'(p);
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One handshake cycle on both DUTs with scoreboard and stall checks.
  task automatic step(input logic iv, input logic [7:0] id, input logic idec,
                      input logic ordy, input logic need_rdy);
    exp_t e;
    in_valid = iv; in_data = id; in_dec = idec; out_ready = ordy;
    #1;
    if (need_rdy) begin
      chk("in_ready_a", a_in_ready, 1);
      chk("in_ready_b", b_in_ready, 1);
    end
    if (stall_a) begin
      chk("hold_data_a", a_out_data, held_a.data);
      chk("hold_dec_a", a_out_dec, held_a.dec);
    end
    if (stall_b) begin
      chk("hold_data_b", b_out_data, held_b.data);
      chk("hold_dec_b", b_out_dec, held_b.dec);
    end
    chk("occ_a", a_occ, qa.size());
    chk("occ_b", b_occ, qb.size());
    chk("inflight_max_a", qa.size() <= D, 1);
    chk("inflight_max_b", qb.size() <= D1, 1);
    if (a_out_valid && ordy) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_a: got word %0h, expected no word", a_out_data);
      end else begin
        e = qa.pop_front();
        chk("data_a", a_out_data, e.data);
        chk("dec_a", a_out_dec, e.dec);
      end
    end
    if (b_out_valid && ordy) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_b: got word %0h, expected no word", b_out_data);
      end else begin
        e = qb.pop_front();
        chk("data_b", b_out_data, e.data);
        chk("dec_b", b_out_dec, e.dec);
      end
    end
    if (iv && a_in_ready) qa.push_back('{model(id, idec, D, P), idec});
    if (iv && b_in_ready) qb.push_back('{model(id, idec, D1, P1), idec});
    stall_a = a_out_valid && !ordy;
    stall_b = b_out_valid && !ordy;
    held_a  = '{a_out_data, a_out_dec};
    held_b  = '{8'(b_out_data), b_out_dec};
    cyc();
  endtask

  // Single word through an idle pipeline: latency, data, mode, drain.
  task automatic lat_test(input vec_t t);
    int la, lb;
    logic [7:0] da;
    logic [1:0] db;
    logic ma, mb;
    la = 0; lb = 0; da = '0; db = '0; ma = 1'b0; mb = 1'b0;
    in_valid = 1'b1; in_data = t.data; in_dec = t.dec; out_ready = 1'b1;
    #1;
    chk("lat_in_ready_a", a_in_ready, 1);
    chk("lat_in_ready_b", b_in_ready, 1);
    cyc();
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (a_out_valid && la == 0) begin la = c; da = a_out_data; ma = a_out_dec; end
      if (b_out_valid && lb == 0) begin lb = c; db = b_out_data; mb = b_out_dec; end
      cyc();
    end
    chk("latency_a", la, D);
    chk("latency_b", lb, D1);
    chk("vec_data_a", da, t.exp_a);
    chk("vec_data_b", db, t.exp_b);
    chk("vec_dec_a", ma, t.dec);
    chk("vec_dec_b", mb, t.dec);
    chk("vec_occ_a", a_occ, 0);
    chk("vec_occ_b", b_occ, 0);
  endtask

  initial begin
    vecs[0] = '{8'h00, 1'b0, 8'hFF, 2'd1};
    vecs[1] = '{8'hE4, 1'b0, 8'h93, 2'd1};
    vecs[2] = '{8'hE4, 1'b1, 8'h39, 2'd3};
    vecs[3] = '{8'hFF, 1'b1, 8'h00, 2'd2};
    vecs[4] = '{8'h1B, 1'b0, 8'hC6, 2'd0};
    vecs[5] = '{8'h5A, 1'b1, 8'hAF, 2'd1};
    stall_a = 1'b0; stall_b = 1'b0;
    held_a = '{8'h00, 1'b0}; held_b = '{8'h00, 1'b0};

    // Reset, with input offered during reset (must be ignored).
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_dec = 1'b0; out_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_out_valid_a", a_out_valid, 0);
    chk("rst_out_data_a", a_out_data, 0);
    chk("rst_out_dec_a", a_out_dec, 0);
    chk("rst_occ_a", a_occ, 0);
    chk("rst_in_ready_a", a_in_ready, 1);
    chk("rst_out_valid_b", b_out_valid, 0);
    chk("rst_out_data_b", b_out_data, 0);
    chk("rst_occ_b", b_occ, 0);
    chk("rst_in_ready_b", b_in_ready, 1);
    cyc();

    for (int i = 0; i < 6; i++) lat_test(vecs[i]);

    // Back-to-back stream with mixed modes and out_ready held high.
    stall_a = 1'b0; stall_b = 1'b0;
    for (int s = 0; s < 22; s++) begin
      chk("stream_valid_a", a_out_valid, (s >= 3 && s <= 18));
      chk("stream_valid_b", b_out_valid, (s >= 1 && s <= 16));
      step(s < 16, 8'(s), s[0], 1'b1, s < 16);
    end

    // Stall: fill, hold, then drain in order.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h20 + 8'(i), i[0], 1'b0, 1'b0);
    #1;
    chk("stall_in_ready_a", a_in_ready, 0);
    chk("stall_occ_a", a_occ, 3);
    chk("stall_in_ready_b", b_in_ready, 0);
    chk("stall_occ_b", b_occ, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("stall_drained_a", qa.size(), 0);
    chk("stall_drained_b", qb.size(), 0);

    // Random valid/ready traffic.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 7, 1'b0);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("rand_drained_a", qa.size(), 0);
    chk("rand_drained_b", qb.size(), 0);

    // Reset with words in flight.
    step(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_occ_a", a_occ, 2);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid_a", a_out_valid, 0);
    chk("midrst_occ_a", a_occ, 0);
    chk("midrst_out_valid_b", b_out_valid, 0);
    chk("midrst_occ_b", b_occ, 0);
    qa.delete(); qb.delete();
    stall_a = 1'b0; stall_b = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    lat_test(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
